// File: rtl/shape_processor_pkg.sv
// Shared definitions for the shape processor front end: CTRL SFR layout,
// shape/operation encodings, legality helpers and the CTRL reset value.
package shape_processor_pkg;

    // Shape encodings; KEEP is only meaningful as a write value.
    typedef enum logic [1:0] {
        SHAPE_RESERVED  = 2'b00,
        SHAPE_RECTANGLE = 2'b01,
        SHAPE_TRIANGLE  = 2'b10,
        SHAPE_KEEP      = 2'b11
    } shape_e;

    // Operation encodings; every other 6-bit value is reserved, KEEP only on writes.
    typedef enum logic [5:0] {
        OP_PERIMETER      = 6'h00,
        OP_AREA           = 6'h01,
        OP_IS_SQUARE      = 6'h10,
        OP_IS_EQUILATERAL = 6'h20,
        OP_IS_ISOSCELES   = 6'h21,
        OP_KEEP           = 6'h3F
    } operation_e;

    // CTRL SFR layout, MSB first.
    typedef struct packed {
        logic [13:0] rsvd_hi;    // [31:18]
        logic [1:0]  shape;      // [17:16]
        logic [9:0]  rsvd_lo;    // [15:6]
        logic [5:0]  operation;  // [5:0]
    } ctrl_sfr_reg;

    localparam ctrl_sfr_reg CTRL_RESET_VALUE = '{
        rsvd_hi:   14'd0,
        shape:     SHAPE_RECTANGLE,
        rsvd_lo:   10'd0,
        operation: OP_PERIMETER
    };

    // Only rectangle and triangle can be stored in CTRL.
    function automatic logic is_reserved_shape(input logic [1:0] shape);
        logic rsvd;
        case (shape)
            SHAPE_RECTANGLE, SHAPE_TRIANGLE: rsvd = 1'b0;
            default:                         rsvd = 1'b1;
        endcase
        return rsvd;
    endfunction

    // Only the five implemented operations can be stored in CTRL.
    function automatic logic is_reserved_operation(input logic [5:0] operation);
        logic rsvd;
        case (operation)
            OP_PERIMETER, OP_AREA, OP_IS_SQUARE,
            OP_IS_EQUILATERAL, OP_IS_ISOSCELES: rsvd = 1'b0;
            default:                            rsvd = 1'b1;
        endcase
        return rsvd;
    endfunction

    // Shape-specific predicates only make sense for their own shape.
    function automatic logic is_legal_combination(input logic [1:0] shape,
                                                  input logic [5:0] operation);
        logic legal;
        case (operation)
            OP_PERIMETER, OP_AREA:
                legal = (shape == SHAPE_RECTANGLE) || (shape == SHAPE_TRIANGLE);
            OP_IS_SQUARE:
                legal = (shape == SHAPE_RECTANGLE);
            OP_IS_EQUILATERAL, OP_IS_ISOSCELES:
                legal = (shape == SHAPE_TRIANGLE);
            default:
                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shape_processor_ctrl_resolve.sv
// Combinational resolution of a CTRL write: applies KEEP fields against the
// current CTRL contents and decides whether the resulting value is legal.
module shape_processor_ctrl_resolve
    import shape_processor_pkg::*;
(
    input  logic [31:0] wr_data,
    input  ctrl_sfr_reg cur_ctrl,
    output ctrl_sfr_reg new_ctrl,
    output logic        accept
);

    logic [1:0] new_shape_s;
    logic [5:0] new_op_s;
    logic       rsvd_unused_s;

    // Reserved write bits and stored reserved bits carry no information.
    assign rsvd_unused_s = ^{wr_data[31:18], wr_data[15:6],
                             cur_ctrl.rsvd_hi, cur_ctrl.rsvd_lo};

    // Resolve KEEP encodings, rebuild CTRL with reserved bits zero, judge legality.
    always_comb begin
        new_shape_s = cur_ctrl.shape;
        new_op_s    = cur_ctrl.operation;
        if (wr_data[17:16] == SHAPE_KEEP) begin
            new_shape_s = cur_ctrl.shape;
        end else begin
            new_shape_s = wr_data[17:16];
        end
        if (wr_data[5:0] == OP_KEEP) begin
            new_op_s = cur_ctrl.operation;
        end else begin
            new_op_s = wr_data[5:0];
        end
        new_ctrl = '{
            rsvd_hi:   14'd0,
            shape:     new_shape_s,
            rsvd_lo:   10'd0,
            operation: new_op_s
        };
        accept = !is_reserved_shape(new_shape_s)
              && !is_reserved_operation(new_op_s)
              && is_legal_combination(new_shape_s, new_op_s);
    end

endmodule

// File: rtl/shape_processor_sequencer.sv
// Front-end sequencer for the shape processor datapath: owns CTRL, issues one
// datapath command per accepted legal write, waits for completion under a
// watchdog and holds the result until the consumer takes it.
module shape_processor_sequencer
    import shape_processor_pkg::*;
#(
    parameter int RESULT_W       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [31:0]         wr_data,
    output logic [31:0]         ctrl_rdata,
    output logic                illegal_wr,
    output logic                dp_start,
    input  logic                dp_ready,
    output logic [1:0]          dp_shape,
    output logic [5:0]          dp_operation,
    input  logic                dp_done,
    input  logic [RESULT_W-1:0] dp_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_timeout,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e          state_r;
    ctrl_sfr_reg     ctrl_r;
    logic [CNT_W-1:0] wdog_cnt_r;
    ctrl_sfr_reg     new_ctrl_s;
    logic            accept_s;

    shape_processor_ctrl_resolve u_resolve (
        .wr_data  (wr_data),
        .cur_ctrl (ctrl_r),
        .new_ctrl (new_ctrl_s),
        .accept   (accept_s)
    );

    // The writer stalls whenever a command is in flight.
    assign wr_ready   = (state_r == ST_IDLE);
    assign ctrl_rdata = ctrl_r;

    // Command sequencing FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ctrl_r       <= CTRL_RESET_VALUE;
            wdog_cnt_r   <= {CNT_W{1'b0}};
            illegal_wr   <= 1'b0;
            dp_start     <= 1'b0;
            dp_shape     <= 2'b00;
            dp_operation <= 6'b000000;
            res_valid    <= 1'b0;
            res_data     <= {RESULT_W{1'b0}};
            res_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            illegal_wr <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_valid) begin
                        if (accept_s) begin
                            ctrl_r       <= new_ctrl_s;
                            dp_start     <= 1'b1;
                            dp_shape     <= new_ctrl_s.shape;
                            dp_operation <= new_ctrl_s.operation;
                            busy         <= 1'b1;
                            state_r      <= ST_START;
                        end else begin
                            illegal_wr <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    // No watchdog here: the datapath may back-pressure indefinitely.
                    if (dp_ready) begin
                        dp_start   <= 1'b0;
                        wdog_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion takes priority over expiry on the same cycle.
                    if (dp_done) begin
                        res_data    <= dp_result;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state_r     <= ST_RESULT;
                    end else if (wdog_cnt_r == CNT_LAST) begin
                        res_data    <= {RESULT_W{1'b0}};
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state_r     <= ST_RESULT;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    dp_start    <= 1'b0;
                    res_valid   <= 1'b0;
                    res_timeout <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_processor_sequencer.sv
// Directed self-checking bench for shape_processor_sequencer.
module tb_shape_processor_sequencer;

    localparam int RESULT_W = 16;
    localparam int TIMEOUT_CYCLES = 64;

    logic                clk;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [31:0]         wr_data;
    logic [31:0]         ctrl_rdata;
    logic                illegal_wr;
    logic                dp_start;
    logic                dp_ready;
    logic [1:0]          dp_shape;
    logic [5:0]          dp_operation;
    logic                dp_done;
    logic [RESULT_W-1:0] dp_result;
    logic                res_valid;
    logic                res_ready;
    logic [RESULT_W-1:0] res_data;
    logic                res_timeout;
    logic                busy;

    int total;
    int bad;

    shape_processor_sequencer #(
        .RESULT_W       (RESULT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .ctrl_rdata   (ctrl_rdata),
        .illegal_wr   (illegal_wr),
        .dp_start     (dp_start),
        .dp_ready     (dp_ready),
        .dp_shape     (dp_shape),
        .dp_operation (dp_operation),
        .dp_done      (dp_done),
        .dp_result    (dp_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_timeout  (res_timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = 32'h0000_0000;
        dp_ready  = 1'b0;
        dp_done   = 1'b0;
        dp_result = 16'h0000;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ctrl", ctrl_rdata, 32'h0001_0000);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dp_start", 32'(dp_start), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_illegal", 32'(illegal_wr), 32'h0);

        // Legal write: triangle / is_equilateral
        wr_valid = 1'b1;
        wr_data  = 32'h0002_0020;
        tick();
        wr_valid = 1'b0;
        chk("t1_dp_start", 32'(dp_start), 32'h1);
        chk("t1_dp_shape", 32'(dp_shape), 32'h2);
        chk("t1_dp_op", 32'(dp_operation), 32'h20);
        chk("t1_ctrl", ctrl_rdata, 32'h0002_0020);
        chk("t1_wr_ready", 32'(wr_ready), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        chk("t1_start_drop", 32'(dp_start), 32'h0);
        dp_done   = 1'b1;
        dp_result = 16'h0001;
        tick();
        dp_done = 1'b0;
        chk("t1_res_valid", 32'(res_valid), 32'h1);
        chk("t1_res_data", 32'(res_data), 32'h0001);
        chk("t1_res_timeout", 32'(res_timeout), 32'h0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_res_drop", 32'(res_valid), 32'h0);
        chk("t1_wr_ready_back", 32'(wr_ready), 32'h1);

        // Illegal pair: keep triangle, is_square
        wr_valid = 1'b1;
        wr_data  = 32'h0003_0010;
        tick();
        wr_valid = 1'b0;
        chk("t2_illegal", 32'(illegal_wr), 32'h1);
        chk("t2_ctrl", ctrl_rdata, 32'h0002_0020);
        chk("t2_no_start", 32'(dp_start), 32'h0);
        chk("t2_wr_ready", 32'(wr_ready), 32'h1);
        tick();
        chk("t2_pulse_once", 32'(illegal_wr), 32'h0);

        // Reserved shape, then reserved op, then keep/keep reissue
        wr_valid = 1'b1;
        wr_data  = 32'h0000_0001;
        tick();
        chk("t3_rsvd_shape", 32'(illegal_wr), 32'h1);
        wr_data = 32'h0001_0005;
        tick();
        chk("t3_rsvd_op", 32'(illegal_wr), 32'h1);
        chk("t3_ctrl_kept", ctrl_rdata, 32'h0002_0020);
        chk("t3_no_start", 32'(dp_start), 32'h0);
        wr_data = 32'h0003_003F;
        tick();
        wr_valid = 1'b0;
        chk("t3_keep_legal", 32'(illegal_wr), 32'h0);
        chk("t3_keep_start", 32'(dp_start), 32'h1);
        chk("t3_keep_shape", 32'(dp_shape), 32'h2);
        chk("t3_keep_op", 32'(dp_operation), 32'h20);
        chk("t3_keep_ctrl", ctrl_rdata, 32'h0002_0020);

        // Back-pressure in START (late dp_done ignored there), then watchdog expiry
        dp_result = 16'hBEEF;
        dp_done   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_start_held", 32'(dp_start), 32'h1);
            chk("t4_fields", 32'({dp_shape, dp_operation}), 32'h0A0);
            chk("t4_no_result", 32'(res_valid), 32'h0);
        end
        dp_done  = 1'b0;
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            tick();
            chk("t4_wait_no_result", 32'(res_valid), 32'h0);
        end
        tick();
        chk("t4_to_valid", 32'(res_valid), 32'h1);
        chk("t4_to_flag", 32'(res_timeout), 32'h1);
        chk("t4_to_data", 32'(res_data), 32'h0000);

        // Stalled write while result is held
        wr_valid = 1'b1;
        wr_data  = 32'h0001_0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall_wr_ready", 32'(wr_ready), 32'h0);
            chk("t5_res_held", 32'(res_valid), 32'h1);
            chk("t5_ctrl_held", ctrl_rdata, 32'h0002_0020);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t5_res_drop", 32'(res_valid), 32'h0);
        chk("t5_wr_ready", 32'(wr_ready), 32'h1);
        chk("t5_not_yet", 32'(dp_start), 32'h0);
        tick();
        wr_valid = 1'b0;
        chk("t5_accept_start", 32'(dp_start), 32'h1);
        chk("t5_accept_shape", 32'(dp_shape), 32'h1);
        chk("t5_accept_op", 32'(dp_operation), 32'h01);
        chk("t5_accept_ctrl", ctrl_rdata, 32'h0001_0001);

        // Reset during WAIT, late dp_done ignored
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_wr_ready", 32'(wr_ready), 32'h1);
        chk("t6_ctrl", ctrl_rdata, 32'h0001_0000);
        chk("t6_res_valid", 32'(res_valid), 32'h0);
        chk("t6_dp_start", 32'(dp_start), 32'h0);
        dp_done   = 1'b1;
        dp_result = 16'h1234;
        tick();
        dp_done = 1'b0;
        chk("t6_late_done", 32'(res_valid), 32'h0);
        chk("t6_late_busy", 32'(busy), 32'h0);
        chk("t6_late_illegal", 32'(illegal_wr), 32'h0);

        // dp_done on the expiry cycle counts as normal completion
        wr_valid = 1'b1;
        wr_data  = 32'h0001_0010;
        tick();
        wr_valid = 1'b0;
        chk("t7_start", 32'(dp_start), 32'h1);
        chk("t7_op", 32'(dp_operation), 32'h10);
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            tick();
        end
        chk("t7_pre_expiry", 32'(res_valid), 32'h0);
        dp_done   = 1'b1;
        dp_result = 16'h00AB;
        tick();
        dp_done = 1'b0;
        chk("t7_valid", 32'(res_valid), 32'h1);
        chk("t7_data", 32'(res_data), 32'h00AB);
        chk("t7_no_timeout", 32'(res_timeout), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
